// File: rtl/connect4_pkg.sv
// Shared types for the drop engine: FSM states and player colour codes.
package connect4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    LAND = 2'd2
  } state_t;

  localparam logic PLAYER_RED   = 1'b0;
  localparam logic PLAYER_GREEN = 1'b1;

  localparam int STEP_W = 8;

endpackage

// File: rtl/drop_engine_if.sv
// Move request / board display bundle between a controller and the engine.
interface drop_engine_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) ();
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic                       make_move;
  logic [CW-1:0]              column;
  logic                       player;
  logic                       clear_board;
  logic                       ready;
  logic [ROWS-1:0][COLS-1:0]  red;
  logic [ROWS-1:0][COLS-1:0]  green;
  logic                       landed;
  logic [RW-1:0]              land_row;
  logic                       illegal;

  modport master (
    output make_move, column, player, clear_board,
    input  ready, red, green, landed, land_row, illegal
  );

  modport slave (
    input  make_move, column, player, clear_board,
    output ready, red, green, landed, land_row, illegal
  );
endinterface

// File: rtl/drop_timer.sv
// Fall step timer: one tick per interval while enabled.
// Define DROP_ACCEL_EN to shorten the interval as the token descends.
module drop_timer
  import connect4_pkg::*;
#(
  parameter int STEP_CYCLES = 16,
  parameter int RW          = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_enable,
  input  logic [RW-1:0] i_row,
  output logic          o_tick
);

`ifdef DROP_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic [STEP_W-1:0] r_cnt;
  logic [STEP_W-1:0] w_ivl;

  always_comb begin
    w_ivl = STEP_W'(STEP_CYCLES);
    if (ACCEL) begin
      if (int'(i_row) >= STEP_CYCLES - 1)
        w_ivl = STEP_W'(1);
      else
        w_ivl = STEP_W'(STEP_CYCLES - int'(i_row));
    end
  end

  assign o_tick = i_enable && (r_cnt == w_ivl - STEP_W'(1));

  always_ff @(posedge clock) begin
    if (reset || !i_enable || o_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + STEP_W'(1);
  end

endmodule

// File: rtl/drop_engine.sv
// Token drop engine: accepts a move, animates the fall, commits the token.
// Optional macro DROP_ACCEL_EN (in drop_timer) accelerates the fall.
module drop_engine
  import connect4_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int STEP_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  drop_engine_if.slave bus
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef logic [ROWS-1:0][COLS-1:0] mat_t;

  state_t        r_ps;
  mat_t          r_red;
  mat_t          r_grn;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_land_row;
  logic [CW-1:0] r_col;
  logic          r_ply;
  logic          r_landed;
  logic          r_illegal;

  logic          w_fall;
  logic          w_tick;
  logic          w_below_free;
  logic          w_req_bad;
  logic [CW-1:0] w_ci;
  logic [CW-1:0] w_top_ci;
  logic [RW-1:0] w_nxt;
  mat_t          w_red;
  mat_t          w_grn;

  assign w_fall = (r_ps == FALL);

  drop_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .RW          (RW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_fall),
    .i_row    (r_row),
    .o_tick   (w_tick)
  );

  // Display bit for column c sits at index COLS-1-c.
  assign w_ci     = CW'(COLS - 1) - r_col;
  assign w_top_ci = CW'(COLS - 1) - bus.column;
  assign w_nxt    = r_row + RW'(1);

  assign w_below_free = (r_row != RW'(ROWS - 1))
                     && !r_red[w_nxt][w_ci]
                     && !r_grn[w_nxt][w_ci];

  assign w_req_bad = (int'(bus.column) >= COLS)
                  || r_red[0][w_top_ci]
                  || r_grn[0][w_top_ci];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ps       <= IDLE;
      r_red      <= '0;
      r_grn      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_ply      <= PLAYER_RED;
      r_landed   <= 1'b0;
      r_land_row <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_landed  <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_ps)
        IDLE: begin
          if (bus.clear_board) begin
            r_red <= '0;
            r_grn <= '0;
          end else if (bus.make_move) begin
            if (w_req_bad) begin
              r_illegal <= 1'b1;
            end else begin
              r_col <= bus.column;
              r_ply <= bus.player;
              r_row <= '0;
              r_ps  <= FALL;
            end
          end
        end
        FALL: begin
          if (w_tick) begin
            if (w_below_free)
              r_row <= w_nxt;
            else
              r_ps <= LAND;
          end
        end
        LAND: begin
          if (r_ply == PLAYER_GREEN)
            r_grn[r_row][w_ci] <= 1'b1;
          else
            r_red[r_row][w_ci] <= 1'b1;
          r_landed   <= 1'b1;
          r_land_row <= r_row;
          r_ps       <= IDLE;
        end
        default: r_ps <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_red = r_red;
    w_grn = r_grn;
    if (r_ps != IDLE) begin
      if (r_ply == PLAYER_GREEN)
        w_grn[r_row][w_ci] = 1'b1;
      else
        w_red[r_row][w_ci] = 1'b1;
    end
  end

  assign bus.ready    = (r_ps == IDLE);
  assign bus.red      = w_red;
  assign bus.green    = w_grn;
  assign bus.landed   = r_landed;
  assign bus.land_row = r_land_row;
  assign bus.illegal  = r_illegal;

endmodule

// File: tb/tb_drop_engine.sv
// Self-checking bench for drop_engine against a timing/board reference model.
module tb_drop_engine;
  import connect4_pkg::*;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int S    = 4;
  localparam int CW   = $clog2(COLS);

`ifdef DROP_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  drop_engine_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  drop_engine #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .STEP_CYCLES (S)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_err  = 0;
  int n_chk  = 0;
  int n_land = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: board contents plus time since the move was accepted.
  bit m_red [ROWS][COLS];
  bit m_grn [ROWS][COLS];
  bit m_busy, m_landed, m_illegal, m_ply;
  int m_lrow, m_n, m_R, m_T, m_col;

  function automatic int ivl(input int r);
    if (ACCEL) return (S - r < 1) ? 1 : S - r;
    return S;
  endfunction

  function automatic int cum(input int j);
    int s = 0;
    for (int r = 0; r < j; r++) s += ivl(r);
    return s;
  endfunction

  function automatic int row_at(input int n, input int R);
    int j = 0;
    while (j < R && cum(j + 1) <= n) j++;
    return j;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          m_red[r][c] = 1'b0;
          m_grn[r][c] = 1'b0;
        end
      m_busy = 0; m_landed = 0; m_illegal = 0; m_lrow = 0;
    end else begin
      m_landed  = 0;
      m_illegal = 0;
      if (!m_busy) begin
        if (bus.clear_board) begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
              m_red[r][c] = 1'b0;
              m_grn[r][c] = 1'b0;
            end
        end else if (bus.make_move) begin
          if (int'(bus.column) >= COLS ||
              m_red[0][bus.column] || m_grn[0][bus.column]) begin
            m_illegal = 1;
          end else begin
            m_busy = 1;
            m_n    = 0;
            m_col  = int'(bus.column);
            m_ply  = bus.player;
            m_R    = 0;
            for (int r = ROWS - 1; r >= 0; r--)
              if (!m_red[r][m_col] && !m_grn[r][m_col]) begin
                m_R = r;
                break;
              end
            m_T = cum(m_R + 1);
          end
        end
      end else begin
        m_n++;
        if (m_n == m_T + 1) begin
          if (m_ply) m_grn[m_R][m_col] = 1'b1;
          else       m_red[m_R][m_col] = 1'b1;
          m_landed = 1;
          m_lrow   = m_R;
          m_busy   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [ROWS-1:0][COLS-1:0] er, eg;
    int tr;
    if (chk_en) begin
      er = '0;
      eg = '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          er[r][COLS-1-c] = m_red[r][c];
          eg[r][COLS-1-c] = m_grn[r][c];
        end
      if (m_busy) begin
        tr = row_at(m_n, m_R);
        if (m_ply) eg[tr][COLS-1-m_col] = 1'b1;
        else       er[tr][COLS-1-m_col] = 1'b1;
      end
      chk("ready",    bus.ready,    !m_busy);
      chk("landed",   bus.landed,   m_landed);
      chk("illegal",  bus.illegal,  m_illegal);
      chk("land_row", bus.land_row, m_lrow);
      chk("red",      bus.red,      er);
      chk("green",    bus.green,    eg);
      if (bus.landed === 1'b1) n_land++;
    end
  end

  // Called at a negedge; returns at the negedge where landed is seen.
  task automatic do_move(input int col, input bit ply, output int lat);
    bus.make_move = 1'b1;
    bus.column    = CW'(col);
    bus.player    = ply;
    @(posedge clk);
    @(negedge clk);
    bus.make_move = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.landed === 1'b1) break;
    end
    chk("landed_seen", bus.landed, 1);
  endtask

  task automatic try_move(input int col, input bit clr);
    bus.make_move   = 1'b1;
    bus.column      = CW'(col);
    bus.player      = PLAYER_RED;
    bus.clear_board = clr;
    @(posedge clk);
    @(negedge clk);
    bus.make_move   = 1'b0;
    bus.clear_board = 1'b0;
  endtask

  initial begin
    int lat, k;
    bus.make_move   = 1'b0;
    bus.column      = '0;
    bus.player      = PLAYER_RED;
    bus.clear_board = 1'b0;

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready",    bus.ready,    1);
    chk("rst_red",      bus.red,      0);
    chk("rst_green",    bus.green,    0);
    chk("rst_landed",   bus.landed,   0);
    chk("rst_illegal",  bus.illegal,  0);
    chk("rst_land_row", bus.land_row, 0);
    rst = 1'b0;
    @(negedge clk);

    do_move(3, PLAYER_RED, lat);
    chk("lat_red",  lat, ACCEL ? 13 : 25);
    chk("row_red",  bus.land_row, 5);
    @(negedge clk);
    chk("red_5_3",  bus.red[5][COLS-1-3], 1);

    do_move(3, PLAYER_GREEN, lat);
    chk("lat_grn",  lat, ACCEL ? 12 : 21);
    chk("row_grn",  bus.land_row, 4);
    @(negedge clk);
    chk("grn_4_3",  bus.green[4][COLS-1-3], 1);

    try_move(2, 1'b1);
    chk("clr_illegal", bus.illegal, 0);
    chk("clr_ready",   bus.ready,   1);
    chk("clr_red",     bus.red,     0);
    chk("clr_green",   bus.green,   0);

    for (int i = 0; i < ROWS; i++) begin
      do_move(0, i[0], lat);
      chk("fill_row", bus.land_row, ROWS - 1 - i);
      @(negedge clk);
    end
    try_move(0, 1'b0);
    chk("full_illegal", bus.illegal, 1);
    chk("full_ready",   bus.ready,   1);
    chk("full_red50",   bus.red[5][COLS-1],   1);
    chk("full_grn00",   bus.green[0][COLS-1], 1);
    @(negedge clk);
    chk("full_pulse1",  bus.illegal, 0);

    try_move(7, 1'b0);
    chk("col7_illegal", bus.illegal, 1);

    try_move(0, 1'b1);
    try_move(1, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_busy", bus.ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_ready", bus.ready, 1);
    chk("mr_red",   bus.red,   0);
    chk("mr_green", bus.green, 0);
    k = n_land;
    repeat (40) @(negedge clk);
    chk("mr_no_land", n_land - k, 0);

    repeat (4000) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 999) == 0);
      bus.make_move   = ($urandom_range(0, 3) == 0);
      bus.column      = CW'($urandom_range(0, 7));
      bus.player      = $urandom_range(0, 1);
      bus.clear_board = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    rst             = 1'b0;
    bus.make_move   = 1'b0;
    bus.clear_board = 1'b0;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/drop_engine.md
DROP_ENGINE -- requirements
Module: drop_engine

Interface
REQ-001 Parameter ROWS, default 16, board height in cells; row 0 is the top row.
REQ-002 Parameter COLS, default 16, board width in cells.
REQ-003 Parameter STEP_CYCLES, default 16, clock cycles per one-row fall step; legal range 1..255.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 make_move  input  1  move request; sampled only while ready=1.
REQ-007 column  input  $clog2(COLS)  target column of the move.
REQ-008 player  input  1  0=red, 1=green.
REQ-009 clear_board  input  1  empties the committed board; honoured only while ready=1.
REQ-010 ready  output  1  high in IDLE only.
REQ-011 red  output  ROWS x COLS  red display matrix; cell (r,c) maps to bit [r][COLS-1-c].
REQ-012 green  output  ROWS x COLS  green display matrix; same mapping.
REQ-013 landed  output  1  one-cycle pulse when a token commits.
REQ-014 land_row  output  $clog2(ROWS)  row of the committed token; valid while landed=1, holds otherwise.
REQ-015 illegal  output  1  one-cycle pulse when a move is rejected.

Function
REQ-016 FSM states are IDLE, FALL and LAND; the FSM enters IDLE after reset.
REQ-017 In IDLE with make_move=1, the move is rejected if column>=COLS or the top cell of the column is occupied: illegal=1 on the next cycle and the FSM stays in IDLE.
REQ-018 A legal move captures column and player, sets token_row=0, clears the step counter and enters FALL on the next edge.
REQ-019 While the FSM is in FALL or LAND, red and green show the committed board ORed with the falling token at (token_row, column) in the player's colour; in IDLE they show the committed board only.
REQ-020 In FALL, the step counter increments every cycle; when it equals interval-1, a step decision is taken and the counter is cleared.
REQ-021 At a step decision, if token_row<ROWS-1 and cell (token_row+1, column) is empty in both colours, token_row increments; otherwise the FSM enters LAND.
REQ-022 In LAND, the token is written into the committed board, landed=1 and land_row=token_row for that one cycle, and the FSM returns to IDLE on the next edge.
REQ-023 Landing latency with a constant interval S: landed is high in cycle (R+1)*S+1 after the accepting edge, where R is the landing row.
REQ-024 make_move, column and player are ignored outside IDLE; no request is queued.
REQ-025 clear_board and make_move together in IDLE: the clear wins, the move is dropped and illegal stays 0.
REQ-026 clear_board outside IDLE is ignored.
REQ-027 Outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

Reset
REQ-028 Reset clears the committed board and token state and sets ps=IDLE, ready=1, landed=0, illegal=0, land_row=0, red=0 and green=0, including when asserted mid-fall.

Configuration
REQ-029 With macro DROP_ACCEL_EN defined, the interval for a token at row r is max(STEP_CYCLES-r, 1); without it, the interval is STEP_CYCLES at every row.

Structure
REQ-030 Shared package connect4_pkg holds the state enum (IDLE, FALL, LAND) and the constants PLAYER_RED=0 and PLAYER_GREEN=1.
REQ-031 Sub-module drop_timer holds the step counter and interval logic; it takes enable and row as inputs and outputs a one-cycle step tick.

Verification
REQ-032 Setup ROWS=6, COLS=7, STEP_CYCLES=4, no macro; red move into an empty column 3 -> landed in cycle 25, land_row=5, red[5][3]=1 thereafter.
REQ-033 Same setup; green move into column 3 after REQ-032 -> landed in cycle 21, land_row=4, green[4][3]=1.
REQ-034 Fill column 0 with 6 moves, then issue a 7th move to column 0 -> illegal pulse, ready stays 1, board unchanged.
REQ-035 Move to column=7 (COLS=7) -> illegal pulse; clear_board together with make_move -> board all-zero, no illegal pulse.
REQ-036 Reset asserted 10 cycles into a fall -> next cycle ready=1, red=0, green=0, landed never pulses.
REQ-037 DROP_ACCEL_EN with STEP_CYCLES=4 into an empty 6-row column -> intervals 4,3,2,1,1,1 and landed in cycle 13.
